dtc_stream_frontend: RTL and testbench

- Sequential front end for the combinational decision-tree classifiers (12-bit feature vector in, 3-bit class out).
- Accepts features as a serial bit stream with a valid/ready handshake and assembles each frame into a parallel vector driven on feat_o.
- Waits a programmable settle latency, then captures the classifier's class from cls_i and presents it on a valid/ready result port with a frame-error flag.
- Sits between the serial sample source and any dtc_* classifier instance; the classifier is instantiated outside this block.

---
 rtl/dtc_pkg.sv | 19 +
 rtl/dtc_stream_frontend_if.sv | 33 +++
 rtl/dtc_bit_assembler.sv | 55 +++++
 rtl/dtc_stream_frontend.sv | 112 +++++++++++
 tb/tb_dtc_stream_frontend.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dtc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dtc_pkg : shared types and default sizes for the dtc_* blocks      |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
package dtc_pkg;

  localparam int DTC_N_FEAT = 12;
  localparam int DTC_N_CLS  = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    EVAL    = 2'd2,
    HOLD    = 2'd3
  } dtc_state_t;

endpackage
`default_nettype wire

// File: rtl/dtc_stream_frontend_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dtc_stream_frontend_if : serial sample input and result handshake  |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
interface dtc_stream_frontend_if
  import dtc_pkg::*;
#(
  parameter int N_CLS = DTC_N_CLS
);

  logic             s_valid;
  logic             s_data;
  logic             s_last;
  logic             s_ready;
  logic             m_valid;
  logic [N_CLS-1:0] m_class;
  logic             m_err;
  logic             m_ready;

  // Master is the sample source / result consumer side.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class, m_err
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class, m_err
  );

endinterface
`default_nettype wire

// File: rtl/dtc_bit_assembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dtc_bit_assembler : serial-to-parallel feature frame builder        |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module dtc_bit_assembler
  import dtc_pkg::*;
#(
  parameter int N_FEAT    = DTC_N_FEAT,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              bit_data,
  input  logic              clr,
  output logic [N_FEAT-1:0] feat,
  output logic              last_pos,
  output logic              cnt_zero
);

  // One extra count value so the counter can sit at N_FEAT after a full frame.
  localparam int c_cnt_w = $clog2(N_FEAT + 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [N_FEAT-1:0]  r_feat;
  logic [c_cnt_w-1:0] w_pos;

  if (LSB_FIRST != 0) begin : g_lsb_first
    assign w_pos = r_cnt;
  end else begin : g_msb_first
    assign w_pos = c_cnt_w'(N_FEAT - 1) - r_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_feat <= '0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_feat <= '0;
    end else if (bit_en) begin
      r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < N_FEAT; i++) begin
        if (w_pos == c_cnt_w'(i)) r_feat[i] <= bit_data;
      end
    end
  end

  assign feat     = r_feat;
  assign last_pos = (r_cnt == c_cnt_w'(N_FEAT - 1));
  assign cnt_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/dtc_stream_frontend.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dtc_stream_frontend : serial feature intake, settle, class capture  |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module dtc_stream_frontend
  import dtc_pkg::*;
#(
  parameter int N_FEAT    = DTC_N_FEAT,
  parameter int N_CLS     = DTC_N_CLS,
  parameter int CLS_LAT   = 0,
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dtc_stream_frontend_if.slave  bus,
  output logic [N_FEAT-1:0]     feat_o,
  input  logic [N_CLS-1:0]      cls_i,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  busy
);

  localparam int c_wait_w = 3;

  dtc_state_t          r_state;
  logic [c_wait_w-1:0] r_wait;
  logic                r_err;
  logic [N_CLS-1:0]    r_class;
  logic                r_merr;
  logic [CNT_W-1:0]    r_frame_cnt;

  logic w_s_ready;
  logic w_bit_acc;
  logic w_last_pos;
  logic w_cnt_zero;
  logic w_res_xfer;

  // Handshake outputs depend on state alone, never on m_ready.
  assign w_s_ready  = (r_state == COLLECT) || (r_state == DRAIN);
  assign w_bit_acc  = bus.s_valid && w_s_ready;
  assign w_res_xfer = (r_state == HOLD) && bus.m_ready;

  dtc_bit_assembler #(
    .N_FEAT    (N_FEAT),
    .LSB_FIRST (LSB_FIRST)
  ) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en   (bus.s_valid && (r_state == COLLECT)),
    .bit_data (bus.s_data),
    .clr      (w_res_xfer),
    .feat     (feat_o),
    .last_pos (w_last_pos),
    .cnt_zero (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_wait      <= '0;
      r_err       <= 1'b0;
      r_class     <= '0;
      r_merr      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_bit_acc) begin
            if (w_last_pos) begin
              r_state <= bus.s_last ? EVAL : DRAIN;
              r_err   <= !bus.s_last;
            end else if (bus.s_last) begin
              r_state <= EVAL;
              r_err   <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_bit_acc && bus.s_last) r_state <= EVAL;
        end
        EVAL: begin
          // r_wait is zero on entry; the capture happens on the final EVAL cycle.
          if (r_wait == c_wait_w'(CLS_LAT)) begin
            r_class <= cls_i;
            r_merr  <= r_err;
            r_wait  <= '0;
            r_state <= HOLD;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_state     <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = (r_state == HOLD);
  assign bus.m_class = r_class;
  assign bus.m_err   = r_merr;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = (r_state != COLLECT) || !w_cnt_zero;

endmodule
`default_nettype wire

// File: tb/tb_dtc_stream_frontend.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dtc_stream_frontend : directed bench for two front-end configs   |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module tb_dtc_stream_frontend;
  import dtc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dtc_stream_frontend_if #(.N_CLS(3)) ifa ();
  dtc_stream_frontend_if #(.N_CLS(3)) ifb ();

  logic [11:0] feat_a, feat_b;
  logic [2:0]  cls_a, cls_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic        busy_a, busy_b;

  // Stub classifier: fixed labels for the two reference vectors, xor mix otherwise.
  function automatic logic [2:0] stub(input logic [11:0] f);
    if (f == 12'h009) return 3'b101;
    if (f == 12'h900) return 3'b110;
    return f[2:0] ^ f[11:9];
  endfunction

  assign cls_a = stub(feat_a);
  assign cls_b = stub(feat_b);

  // A: LSB-first, no settle latency.  B: MSB-first, 3-cycle settle, 2-bit counter.
  dtc_stream_frontend #(.CLS_LAT(0), .LSB_FIRST(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .feat_o(feat_a),
    .cls_i(cls_a), .frame_cnt(cnt_a), .busy(busy_a)
  );

  dtc_stream_frontend #(.CLS_LAT(3), .LSB_FIRST(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .feat_o(feat_b),
    .cls_i(cls_b), .frame_cnt(cnt_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit sel, input logic v, input logic d, input logic l);
    if (sel) begin ifb.s_valid = v; ifb.s_data = d; ifb.s_last = l; end
    else     begin ifa.s_valid = v; ifa.s_data = d; ifa.s_last = l; end
  endtask

  task automatic set_mready(input bit sel, input logic r);
    if (sel) ifb.m_ready = r;
    else     ifa.m_ready = r;
  endtask

  function automatic logic g_mvalid(input bit sel);
    return sel ? ifb.m_valid : ifa.m_valid;
  endfunction
  function automatic logic [2:0] g_mclass(input bit sel);
    return sel ? ifb.m_class : ifa.m_class;
  endfunction
  function automatic logic g_merr(input bit sel);
    return sel ? ifb.m_err : ifa.m_err;
  endfunction
  function automatic logic g_sready(input bit sel);
    return sel ? ifb.s_ready : ifa.s_ready;
  endfunction
  function automatic logic [11:0] g_feat(input bit sel);
    return sel ? feat_b : feat_a;
  endfunction
  function automatic logic [15:0] g_cnt(input bit sel);
    return sel ? {14'b0, cnt_b} : cnt_a;
  endfunction
  function automatic logic g_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // bits[0] is sent first; s_last rides on the n-th bit.
  task automatic send(input bit sel, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (i >= 12) check("drain_sready", g_sready(sel), 1'b1);
      set_in(sel, 1'b1, bits[i], (i == n - 1));
      tick();
    end
    set_in(sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_result(input bit sel, input string tag, input int exp_lat);
    int c = 0;
    while (!g_mvalid(sel) && c < 20) begin
      tick();
      c++;
    end
    check({tag, "_latency"}, c, exp_lat);
  endtask

  task automatic take_result(input bit sel, input string tag, input logic [11:0] ef,
                             input logic [2:0] ec, input logic ee, input logic [15:0] en);
    check({tag, "_feat"},  g_feat(sel),   ef);
    check({tag, "_class"}, g_mclass(sel), ec);
    check({tag, "_err"},   g_merr(sel),   ee);
    check({tag, "_sready_hold"}, g_sready(sel), 1'b0);
    set_mready(sel, 1'b1);
    tick();
    set_mready(sel, 1'b0);
    check({tag, "_mvalid_after"}, g_mvalid(sel), 1'b0);
    check({tag, "_frame_cnt"},    g_cnt(sel),    en);
    check({tag, "_feat_clr"},     g_feat(sel),   12'h000);
  endtask

  task automatic check_reset(input bit sel, input string tag);
    check({tag, "_feat"},   g_feat(sel),   12'h000);
    check({tag, "_mvalid"}, g_mvalid(sel), 1'b0);
    check({tag, "_mclass"}, g_mclass(sel), 3'b000);
    check({tag, "_merr"},   g_merr(sel),   1'b0);
    check({tag, "_cnt"},    g_cnt(sel),    16'h0000);
    check({tag, "_sready"}, g_sready(sel), 1'b1);
    check({tag, "_busy"},   g_busy(sel),   1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    set_mready(1'b0, 1'b0);
    set_mready(1'b1, 1'b0);
    repeat (2) tick();
    check_reset(1'b0, "rst_a");
    check_reset(1'b1, "rst_b");
    rst_n = 1'b1;
    tick();

    // Normal LSB-first frame, one-cycle result latency.
    send(1'b0, 32'h009, 12);
    check("norm_feat_eval", feat_a, 12'h009);
    wait_result(1'b0, "norm", 1);
    take_result(1'b0, "norm", 12'h009, 3'b101, 1'b0, 16'd1);

    // m_ready with no pending result does nothing.
    set_mready(1'b0, 1'b1);
    repeat (2) tick();
    set_mready(1'b0, 1'b0);
    check("idle_mready_cnt", cnt_a, 16'd1);
    check("idle_mready_mvalid", ifa.m_valid, 1'b0);

    // Short frame: 5 ones, last on the 5th.
    send(1'b0, 32'h1F, 5);
    wait_result(1'b0, "short", 1);
    take_result(1'b0, "short", 12'h01F, 3'b111, 1'b1, 16'd2);

    // Long frame: 15 ones; the extra three are drained.
    send(1'b0, 32'h7FFF, 15);
    wait_result(1'b0, "long", 1);
    take_result(1'b0, "long", 12'hFFF, 3'b000, 1'b1, 16'd3);
    repeat (3) tick();
    check("long_single_result", ifa.m_valid, 1'b0);
    check("long_cnt_stable", cnt_a, 16'd3);

    // Reset in the middle of a frame.
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check("partial_feat", feat_a, 12'h03F);
    check("partial_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #2;
    check_reset(1'b0, "midrst_a");
    tick();
    rst_n = 1'b1;
    tick();
    send(1'b0, 32'h009, 12);
    wait_result(1'b0, "postrst", 1);
    take_result(1'b0, "postrst", 12'h009, 3'b101, 1'b0, 16'd1);

    // MSB-first with settle latency 3 and 5 cycles of backpressure.
    send(1'b1, 32'h009, 12);
    check("msb_feat_eval", feat_b, 12'h900);
    check("msb_sready_eval", ifb.s_ready, 1'b0);
    wait_result(1'b1, "msb", 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_mvalid", ifb.m_valid, 1'b1);
      check("bp_mclass", ifb.m_class, 3'b110);
      check("bp_feat",   feat_b,      12'h900);
      check("bp_sready", ifb.s_ready, 1'b0);
    end
    take_result(1'b1, "msb", 12'h900, 3'b110, 1'b0, 16'd1);

    // Two-bit frame counter wraps: 2,3,0,1 after the first frame.
    for (int k = 2; k <= 5; k++) begin
      send(1'b1, 32'h009, 12);
      wait_result(1'b1, "wrap", 4);
      take_result(1'b1, "wrap", 12'h900, 3'b110, 1'b0, 16'(k % 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
